// File: rtl/breath_ctrl_pkg.sv
// breath_ctrl_pkg
// Shared definitions for the LED breathing sequencer: the FSM state
// encoding (also visible on the state port) and a width helper used to size
// the duty and hold counters from the module parameters.
package breath_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RAMP_UP   = 3'd1,
      ST_HOLD_HI   = 3'd2,
      ST_RAMP_DOWN = 3'd3,
      ST_HOLD_LO   = 3'd4,
      ST_DONE      = 3'd5
   } breathState_e;

   localparam int STATE_W = 3;

   // Number of bits needed to hold every value from 0 up to maxVal.
   // Never returns less than 1 so that degenerate parameters still give a
   // legal vector.
   function automatic int widthFor(input int maxVal);
      int w;
      w = $clog2(maxVal + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/breath_ctrl_pwm_timebase.sv
// pwm_timebase
// Microsecond prescaler and PWM position counter for the breathing LED.
// us_cnt divides the clock down to 1 us ticks; pos_cnt walks through the PWM
// period one microsecond at a time. Both counters are held at zero while clr
// is high so that a fresh enable always starts on a period boundary.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   clr      in   synchronous clear of both counters
//   tick_us  out  high on the last clk of each microsecond
//   tick_per out  high on the last clk of each PWM period
//   pos_cnt  out  position inside the PWM period, 0..PWM_PERIOD_US-1
module pwm_timebase #(
   parameter int CLK_PER_US    = 24,
   parameter int PWM_PERIOD_US = 1000,
   parameter int PW            = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   output logic          tick_us,
   output logic          tick_per,
   output logic [PW-1:0] pos_cnt
);

   localparam int UW = $clog2(CLK_PER_US);

   logic [UW-1:0] us_q;
   logic [UW-1:0] us_d;
   logic [PW-1:0] pos_q;
   logic [PW-1:0] pos_d;

   assign tick_us  = (us_q == UW'(CLK_PER_US - 1));
   assign tick_per = tick_us && (pos_q == PW'(PWM_PERIOD_US - 1));
   assign pos_cnt  = pos_q;

   // Next-state for the two cascaded counters. The position counter only
   // moves on a microsecond tick and wraps at the end of the period.
   always_comb begin
      us_d  = us_q;
      pos_d = pos_q;
      if (clr) begin
         us_d  = '0;
         pos_d = '0;
      end else begin
         us_d = tick_us ? '0 : us_q + UW'(1);
         if (tick_per) begin
            pos_d = '0;
         end else if (tick_us) begin
            pos_d = pos_q + PW'(1);
         end
      end
   end

   // Counter registers, cleared asynchronously on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         us_q  <= '0;
         pos_q <= '0;
      end else begin
         us_q  <= us_d;
         pos_q <= pos_d;
      end
   end

endmodule

// File: rtl/breath_ctrl.sv
// breath_ctrl
// Breathing-LED sequencer. Steps the PWM duty up one microsecond per PWM
// period, holds at full brightness, steps back down, holds dark, and then
// either repeats or parks in DONE when one_shot is set. Dropping en aborts
// immediately back to IDLE with the LED off.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   en         in   run enable, level-sensitive
//   one_shot   in   1 = stop after one breath, 0 = repeat
//   led_out    out  registered PWM output to the LED pin
//   duty       out  current duty in us (0..PWM_PERIOD_US)
//   state      out  FSM state encoding
//   cycle_done out  one-clk pulse at the end of each completed breath
module breath_ctrl
   import breath_ctrl_pkg::*;
#(
   parameter int   CLK_PER_US    = 24,
   parameter int   PWM_PERIOD_US = 1000,
   parameter int   HOLD_HI_MS    = 200,
   parameter int   HOLD_LO_MS    = 200,
   localparam int  DW            = widthFor(PWM_PERIOD_US)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               one_shot,
   output logic               led_out,
   output logic [DW-1:0]      duty,
   output logic [STATE_W-1:0] state,
   output logic               cycle_done
);

   localparam int HOLD_MAX = (HOLD_HI_MS > HOLD_LO_MS) ? HOLD_HI_MS : HOLD_LO_MS;
   localparam int HW       = widthFor(HOLD_MAX);

   breathState_e  state_q;
   breathState_e  state_d;
   logic [DW-1:0] duty_q;
   logic [DW-1:0] duty_d;
   logic [HW-1:0] hold_q;
   logic [HW-1:0] hold_d;
   logic          cdone_q;
   logic          cdone_d;
   logic          led_q;
   logic          led_d;

   logic          tickUs;
   logic          tickPer;
   logic [DW-1:0] pos;
   logic          stepTick;

   pwm_timebase #(
      .CLK_PER_US    (CLK_PER_US),
      .PWM_PERIOD_US (PWM_PERIOD_US),
      .PW            (DW)
   ) u_timebase (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (!en),
      .tick_us  (tickUs),
      .tick_per (tickPer),
      .pos_cnt  (pos)
   );

   // Profile steps land only on the last microsecond of a PWM period, so the
   // duty never changes part-way through a period and the LED never glitches.
   assign stepTick = tickUs && tickPer;

   // Breathing FSM next-state. Everything defaults to "hold"; en low
   // overrides the whole profile and also suppresses the end-of-breath pulse
   // when both happen on the same clk.
   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      hold_d  = hold_q;
      cdone_d = 1'b0;
      if (!en) begin
         state_d = ST_IDLE;
         duty_d  = '0;
         hold_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_RAMP_UP;
               duty_d  = '0;
               hold_d  = '0;
            end
            ST_RAMP_UP: begin
               if (stepTick) begin
                  duty_d = duty_q + DW'(1);
                  if (duty_q == DW'(PWM_PERIOD_US - 1)) begin
                     state_d = ST_HOLD_HI;
                     hold_d  = '0;
                  end
               end
            end
            ST_HOLD_HI: begin
               if (stepTick) begin
                  if (hold_q == HW'(HOLD_HI_MS - 1)) begin
                     state_d = ST_RAMP_DOWN;
                     hold_d  = '0;
                  end else begin
                     hold_d = hold_q + HW'(1);
                  end
               end
            end
            ST_RAMP_DOWN: begin
               if (stepTick) begin
                  duty_d = duty_q - DW'(1);
                  if (duty_q == DW'(1)) begin
                     state_d = ST_HOLD_LO;
                     hold_d  = '0;
                  end
               end
            end
            ST_HOLD_LO: begin
               if (stepTick) begin
                  if (hold_q == HW'(HOLD_LO_MS - 1)) begin
                     cdone_d = 1'b1;
                     hold_d  = '0;
                     duty_d  = '0;
                     state_d = one_shot ? ST_DONE : ST_RAMP_UP;
                  end else begin
                     hold_d = hold_q + HW'(1);
                  end
               end
            end
            ST_DONE: begin
               duty_d = '0;
            end
            default: begin
               state_d = ST_IDLE;
               duty_d  = '0;
               hold_d  = '0;
            end
         endcase
      end
   end

   // The LED compare uses the registered duty and position so that the pin
   // is driven straight from a flop, one clk behind the counters.
   assign led_d = en && (pos < duty_q);

   // State, duty, hold counter and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         duty_q  <= '0;
         hold_q  <= '0;
         cdone_q <= 1'b0;
         led_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         duty_q  <= duty_d;
         hold_q  <= hold_d;
         cdone_q <= cdone_d;
         led_q   <= led_d;
      end
   end

   assign led_out    = led_q;
   assign duty       = duty_q;
   assign state      = state_q;
   assign cycle_done = cdone_q;

endmodule

// File: tb/tb_breath_ctrl.sv
// tb_breath_ctrl
// Directed bench for breath_ctrl with a tiny profile: 2 clk per us, 4 us
// period, 2-period holds, so one PWM period is 8 clk and a breath is 96 clk.
// Edge E0 is the first rising edge that samples en high; the counters start
// from zero at that edge, so profile steps land on E7, E15, E23, ...
module tb_breath_ctrl;

   localparam int CLK_PER_US    = 2;
   localparam int PWM_PERIOD_US = 4;
   localparam int HOLD_HI_MS    = 2;
   localparam int HOLD_LO_MS    = 2;
   localparam int DW            = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic          one_shot;
   logic          led_out;
   logic [DW-1:0] duty;
   logic [2:0]    state;
   logic          cycle_done;

   int passCount  = 0;
   int checkCount = 0;
   int failCount  = 0;
   int edgeIdx    = 0;
   int cdCount    = 0;
   int cdSnap     = 0;
   int highCount  = 0;

   breath_ctrl #(
      .CLK_PER_US    (CLK_PER_US),
      .PWM_PERIOD_US (PWM_PERIOD_US),
      .HOLD_HI_MS    (HOLD_HI_MS),
      .HOLD_LO_MS    (HOLD_LO_MS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .one_shot   (one_shot),
      .led_out    (led_out),
      .duty       (duty),
      .state      (state),
      .cycle_done (cycle_done)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Count end-of-breath pulses away from the active edge so each one-clk
   // pulse is seen exactly once.
   always @(negedge clk) begin
      if (cycle_done === 1'b1) cdCount++;
   end

   task automatic applyStimulus(input logic enV, input logic oneShotV);
      en       = enV;
      one_shot = oneShotV;
   endtask

   task automatic runEdges(input int n);
      repeat (n) begin
         @(posedge clk);
         edgeIdx++;
      end
      #1;
   endtask

   task automatic gotoEdge(input int target);
      runEdges(target - edgeIdx);
   endtask

   task automatic countHigh(input int n, output int c);
      c = 0;
      repeat (n) begin
         @(posedge clk);
         edgeIdx++;
         #1;
         if (led_out === 1'b1) c++;
      end
   endtask

   task automatic checkOutput(input string tag, input logic expLed, input logic [DW-1:0] expDuty,
                              input logic [2:0] expState, input logic expCd);
      logic [DW+4:0] obs;
      logic [DW+4:0] exp;
      obs = {led_out, duty, state, cycle_done};
      exp = {expLed, expDuty, expState, expCd};
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed led=%b duty=%0d state=%0d cd=%b, expected led=%b duty=%0d state=%0d cd=%b",
                tag, led_out, duty, state, cycle_done, expLed, expDuty, expState, expCd);
      end
   endtask

   task automatic checkValue(input string tag, input int obs, input int exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Directed sequence: reset, a continuous breath with PWM shape checks,
   // asynchronous reset mid-run, one-shot, abort and en/tick collision.
   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0);
      runEdges(3);
      checkOutput("reset_values", 1'b0, 3'd0, 3'd0, 1'b0);
      rst_n = 1'b1;
      runEdges(2);
      checkOutput("idle_en_low", 1'b0, 3'd0, 3'd0, 1'b0);

      $display("[TB] continuous breath");
      applyStimulus(1'b1, 1'b0);
      edgeIdx = -1;
      gotoEdge(0);
      checkOutput("entry", 1'b0, 3'd0, 3'd1, 1'b0);
      gotoEdge(6);
      checkOutput("ramp_pre", 1'b0, 3'd0, 3'd1, 1'b0);
      gotoEdge(7);
      checkOutput("duty1", 1'b0, 3'd1, 3'd1, 1'b0);
      countHigh(8, highCount);
      checkValue("pwm_duty1_high", highCount, 2);
      checkOutput("duty2", 1'b0, 3'd2, 3'd1, 1'b0);
      gotoEdge(23);
      checkOutput("duty3", 1'b0, 3'd3, 3'd1, 1'b0);
      gotoEdge(31);
      checkOutput("duty4_hold_hi", 1'b0, 3'd4, 3'd2, 1'b0);
      countHigh(8, highCount);
      checkValue("pwm_duty4_high", highCount, 8);
      gotoEdge(46);
      checkOutput("hold_hi_end", 1'b1, 3'd4, 3'd2, 1'b0);
      gotoEdge(47);
      checkOutput("ramp_down_entry", 1'b1, 3'd4, 3'd3, 1'b0);
      gotoEdge(55);
      checkOutput("down3", 1'b1, 3'd3, 3'd3, 1'b0);
      gotoEdge(63);
      checkOutput("down2", 1'b0, 3'd2, 3'd3, 1'b0);
      gotoEdge(71);
      checkOutput("down1", 1'b0, 3'd1, 3'd3, 1'b0);
      gotoEdge(79);
      checkOutput("hold_lo_entry", 1'b0, 3'd0, 3'd4, 1'b0);
      cdSnap = cdCount;
      gotoEdge(94);
      checkOutput("hold_lo_end", 1'b0, 3'd0, 3'd4, 1'b0);
      gotoEdge(95);
      checkOutput("cycle_done", 1'b0, 3'd0, 3'd1, 1'b1);
      gotoEdge(96);
      checkOutput("cycle_done_drop", 1'b0, 3'd0, 3'd1, 1'b0);
      checkValue("cd_pulses_breath1", cdCount - cdSnap, 1);
      gotoEdge(121);
      checkOutput("breath2_duty3", 1'b1, 3'd3, 3'd1, 1'b0);

      $display("[TB] asynchronous reset mid-run");
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset", 1'b0, 3'd0, 3'd0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      runEdges(2);
      rst_n = 1'b1;
      runEdges(1);

      $display("[TB] one-shot");
      cdSnap = cdCount;
      applyStimulus(1'b1, 1'b1);
      edgeIdx = -1;
      gotoEdge(95);
      checkOutput("oneshot_done", 1'b0, 3'd0, 3'd5, 1'b1);
      gotoEdge(96);
      checkOutput("oneshot_park", 1'b0, 3'd0, 3'd5, 1'b0);
      countHigh(40, highCount);
      checkValue("done_led_high", highCount, 0);
      checkOutput("done_hold", 1'b0, 3'd0, 3'd5, 1'b0);
      checkValue("cd_pulses_oneshot", cdCount - cdSnap, 1);
      applyStimulus(1'b0, 1'b1);
      runEdges(1);
      checkOutput("done_exit", 1'b0, 3'd0, 3'd0, 1'b0);
      applyStimulus(1'b1, 1'b1);
      edgeIdx = -1;
      gotoEdge(0);
      checkOutput("restart", 1'b0, 3'd0, 3'd1, 1'b0);
      gotoEdge(7);
      checkOutput("restart_duty1", 1'b0, 3'd1, 3'd1, 1'b0);

      $display("[TB] abort during ramp down");
      gotoEdge(65);
      checkOutput("abort_pre", 1'b1, 3'd2, 3'd3, 1'b0);
      cdSnap = cdCount;
      applyStimulus(1'b0, 1'b1);
      runEdges(1);
      checkOutput("abort_idle", 1'b0, 3'd0, 3'd0, 1'b0);
      runEdges(1);
      checkOutput("abort_led", 1'b0, 3'd0, 3'd0, 1'b0);
      runEdges(20);
      checkValue("abort_no_cd", cdCount - cdSnap, 0);

      $display("[TB] en drop on final hold tick");
      applyStimulus(1'b1, 1'b0);
      edgeIdx = -1;
      gotoEdge(94);
      checkOutput("collide_pre", 1'b0, 3'd0, 3'd4, 1'b0);
      cdSnap = cdCount;
      applyStimulus(1'b0, 1'b0);
      runEdges(1);
      checkOutput("collide", 1'b0, 3'd0, 3'd0, 1'b0);
      runEdges(2);
      checkValue("collide_no_cd", cdCount - cdSnap, 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
